popcount_select: RTL and testbench

//   Inverse of the popcount datapath: popcount gives rank (how many ones); this block gives select.
//   It returns the bit index of the k-th set bit (k is 1-based) in a DATA_WIDTH-bit vector.
//   The search is sequential: one CHUNK-bit word is scanned per cycle, then one SUB-bit byte per cycle.
//   It sits beside the popcount unit in the bit-vector engine and serves indexed lookups.

---
 rtl/popcount_select.sv | 94 +++++++++
 tb/tb_popcount_select.sv | 124 ++++++++++++
 2 files changed

// File: rtl/popcount_select.sv
// popcount_select: sequential select, returns the bit index of the k-th set bit (chunk scan, then byte resolve)
module popcount_select #(
  parameter int DATA_WIDTH = 1024,
  parameter int CHUNK      = 64,
  parameter int SUB        = 8,
  parameter int IW         = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] vec_in,
  input  logic [IW:0]           k_in,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [IW-1:0]         index
);
  localparam int NC = DATA_WIDTH / CHUNK;
  localparam int NB = CHUNK / SUB;
  localparam int CW = NC > 1 ? $clog2(NC) : 1;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam int SW = SUB > 1 ? $clog2(SUB) : 1;
  localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, RESOLVE = 2'd2, DONE = 2'd3;
  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] vec;
  logic [IW:0]           k, acc, rem, cnt, bc, seen;
  logic [CW-1:0]         c;
  logic [BW-1:0]         j;
  logic [CHUNK-1:0]      cw;
  logic [SUB-1:0]        bw;
  logic [SW-1:0]         pos;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    cw   = vec[c*CHUNK +: CHUNK];
    bw   = cw[j*SUB +: SUB];
    cnt  = '0;
    bc   = '0;
    seen = '0;
    pos  = '0;
    for (int i = 0; i < CHUNK; i++) cnt = cnt + (IW+1)'(cw[i]);
    for (int i = 0; i < SUB; i++) begin
      bc = bc + (IW+1)'(bw[i]);
      if (bw[i]) begin
        seen = seen + 1'b1;
        if (seen == rem) pos = SW'(i);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vec   <= '0;
      k     <= '0;
      acc   <= '0;
      rem   <= '0;
      c     <= '0;
      j     <= '0;
      found <= 1'b0;
      index <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          vec   <= vec_in;
          k     <= k_in;
          acc   <= '0;
          c     <= '0;
          j     <= '0;
          found <= 1'b0;
          index <= '0;
          state <= k_in == '0 ? DONE : SCAN;
        end
        SCAN: if (acc + cnt >= k) begin
          rem   <= k - acc;
          j     <= '0;
          state <= RESOLVE;
        end else begin
          acc <= acc + cnt;
          if (c == CW'(NC - 1)) state <= DONE;
          else c <= c + 1'b1;
        end
        RESOLVE: if (bc >= rem) begin
          index <= IW'(c) * IW'(CHUNK) + IW'(j) * IW'(SUB) + IW'(pos);
          found <= 1'b1;
          state <= DONE;
        end else begin
          rem <= rem - bc;
          j   <= j + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_popcount_select.sv
// tb_popcount_select: directed and random checks of popcount_select against a software select model
module tb_popcount_select;
  localparam int DW = 1024;
  localparam int IW = 10;
  logic          clk = 0;
  logic          rst = 1;
  logic          start = 0;
  logic [DW-1:0] vec_in = '0;
  logic [IW:0]   k_in = '0;
  logic          busy, done, found;
  logic [IW-1:0] index;
  int checks = 0;
  int errors = 0;

  popcount_select dut (
    .clk(clk), .rst(rst), .start(start), .vec_in(vec_in), .k_in(k_in),
    .busy(busy), .done(done), .found(found), .index(index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference select: scan positions low to high, counting ones.
  task automatic model(input logic [DW-1:0] v, input int k, output int f, output int idx, output int lat);
    int n;
    f = 0; idx = 0; lat = k == 0 ? 1 : 1 + DW / 64; n = 0;
    if (k != 0)
      for (int p = 0; p < DW; p++)
        if (v[p]) begin
          n++;
          if (n == k && f == 0) begin
            f = 1; idx = p; lat = 3 + p / 64 + (p % 64) / 8;
          end
        end
  endtask

  task automatic go(input logic [DW-1:0] v, input int k);
    @(negedge clk);
    chk("idle_before_start", {busy, done}, 0);
    vec_in = v; k_in = (IW+1)'(k); start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!done) chk("busy_while_running", busy, 1);
    end while (!done && n < 40);
    chk("done_seen", done, 1);
  endtask

  task automatic run(input string tag, input logic [DW-1:0] v, input int k);
    int f, idx, lat, n;
    model(v, k, f, idx, lat);
    go(v, k);
    wait_done(n);
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_found"}, int'(found), f);
    chk({tag, "_index"}, int'(index), idx);
  endtask

  initial begin
    logic [DW-1:0] v4, v;
    int f, idx, lat, n, k;
    v4 = '0; v4[3] = 1; v4[64] = 1; v4[65] = 1; v4[500] = 1; v4[1000] = 1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {busy, done, found, 10'(index)}, 0);
    rst = 0;
    run("ones_k1", '1, 1);
    run("ones_k1024", '1, 1024);
    v = '0; v[700] = 1;
    run("bit700", v, 1);
    run("sparse_k4", v4, 4);
    run("sparse_k6_miss", v4, 6);
    run("sparse_k0", v4, 0);
    run("ones_k1025_miss", '1, 1025);
    @(negedge clk);
    chk("found_held", int'(found), 0);
    chk("done_pulse_once", int'(done), 0);
    // start while busy must be ignored
    go(v4, 4);
    @(negedge clk);
    vec_in = '1; k_in = 1; start = 1;
    @(negedge clk);
    start = 0;
    wait_done(n);
    chk("ignore_busy_found", int'(found), 1);
    chk("ignore_busy_index", int'(index), 500);
    // reset in the middle of a long search
    go('1, 1024);
    repeat (4) begin
      @(negedge clk);
      chk("no_done_before_rst", int'(done), 0);
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_mid_outputs", {busy, done, found, 10'(index)}, 0);
    repeat (30) begin
      @(negedge clk);
      chk("rst_mid_no_done", int'(done), 0);
    end
    run("after_rst", v4, 5);
    // random vectors, dense and sparse, back-to-back
    for (int t = 0; t < 80; t++) begin
      for (int w = 0; w < DW / 32; w++)
        v[32*w +: 32] = t % 2 ? $urandom & $urandom & $urandom : $urandom;
      k = t % 2 ? int'($urandom_range(0, 200)) : int'($urandom_range(0, 1025));
      run("rand", v, k);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
